// File: rtl/multicycle_controlunit_if.sv
// Unified memory port between the multi-cycle control unit (master) and memory (slave).
interface multicycle_controlunit_if;
    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output iord,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  iord,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_controlunit.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32-subset core, sharing one memory port.
// Optional feature macro MCU_TRAP_EN: illegal-opcode and memory-timeout traps.
module multicycle_controlunit #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                      clock,
    input  logic                      reset,
    multicycle_controlunit_if.master  bus,
    input  logic [31:0]               inst,
    input  logic [3:0]                flags,
    output logic                      ir_we,
    output logic                      pc_we,
    output logic                      pc_src,
    output logic                      rf_we,
    output logic [1:0]                wb_sel,
    output logic                      alu_src,
    output logic [3:0]                alu_op,
    output logic [1:0]                imm_sel,
    output logic                      instr_done,
    output logic                      trap,
    output logic [2:0]                state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_ILLEGAL
    } class_e;

    state_e      state_q, state_d;
    class_e      class_q, class_dec;
    logic [7:0]  wait_q, wait_d;
    logic        taken;
    logic        unused_inst;

    function automatic class_e decode_class(input logic [6:0] op);
        case (op)
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b0000011: return C_LOAD;
            7'b0100011: return C_STORE;
            7'b1100011: return C_BRANCH;
            7'b1101111: return C_JAL;
            default:    return C_ILLEGAL;
        endcase
    endfunction

    // flags = {V,C,N,Z}; signed compare uses N^V.
    function automatic logic branch_taken(input logic [2:0] f3, input logic [3:0] fl);
        case (f3)
            3'b000:  return fl[0];
            3'b001:  return !fl[0];
            3'b100:  return fl[1] ^ fl[3];
            3'b101:  return !(fl[1] ^ fl[3]);
            default: return 1'b0;
        endcase
    endfunction

    assign class_dec   = decode_class(inst[6:0]);
    assign taken       = branch_taken(inst[14:12], flags);
    assign unused_inst = ^{inst[31], inst[29:15], inst[11:7], flags[2]};

`ifdef MCU_TRAP_EN
    logic wait_expired;
    assign wait_expired = (wait_q == 8'(MEM_TIMEOUT)) && !bus.mem_ready;
`else
    logic unused_timeout;
    assign unused_timeout = (wait_q == 8'(MEM_TIMEOUT));
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (bus.mem_ready) state_d = S_DECODE;
`ifdef MCU_TRAP_EN
                else if (wait_expired) state_d = S_TRAP;
`endif
            end
            S_DECODE: begin
                state_d = S_EXEC;
`ifdef MCU_TRAP_EN
                if (class_dec == C_ILLEGAL) state_d = S_TRAP;
`endif
            end
            S_EXEC: begin
                case (class_q)
                    C_R, C_I:         state_d = S_WB;
                    C_LOAD, C_STORE:  state_d = S_MEM;
                    default:          state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (bus.mem_ready) state_d = (class_q == C_LOAD) ? S_WB : S_FETCH;
`ifdef MCU_TRAP_EN
                else if (wait_expired) state_d = S_TRAP;
`endif
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // Counts consecutive stalled memory cycles; saturates so an unbounded wait never wraps.
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q || bus.mem_ready)
            wait_d = 8'd0;
        else if ((state_q == S_FETCH || state_q == S_MEM) && wait_q != 8'hFF)
            wait_d = wait_q + 8'd1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_FETCH;
            class_q <= C_R;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == S_DECODE) class_q <= class_dec;
        end
    end

    always_comb begin
        bus.mem_req = 1'b0;
        bus.mem_we  = 1'b0;
        bus.iord    = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 1'b0;
        rf_we       = 1'b0;
        wb_sel      = 2'd0;
        alu_src     = 1'b0;
        alu_op      = 4'd0;
        imm_sel     = 2'd0;
        instr_done  = 1'b0;
        trap        = 1'b0;
        state       = 3'd0;
        if (reset) begin
            state = state_q;
            case (state_q)
                S_FETCH: begin
                    bus.mem_req = 1'b1;
                    if (bus.mem_ready) begin
                        ir_we = 1'b1;
                        pc_we = 1'b1;
                    end
                end
                S_EXEC: begin
                    case (class_q)
                        C_R: begin
                            alu_op = {inst[30], inst[14:12]};
                        end
                        C_I: begin
                            alu_src = 1'b1;
                            alu_op  = {inst[30] & (inst[14:12] == 3'b101), inst[14:12]};
                        end
                        C_LOAD: begin
                            alu_src = 1'b1;
                        end
                        C_STORE: begin
                            alu_src = 1'b1;
                            imm_sel = 2'd1;
                        end
                        C_BRANCH: begin
                            alu_op     = 4'b1000;
                            imm_sel    = 2'd2;
                            pc_we      = taken;
                            pc_src     = taken;
                            instr_done = 1'b1;
                        end
                        C_JAL: begin
                            imm_sel    = 2'd3;
                            rf_we      = 1'b1;
                            wb_sel     = 2'd2;
                            pc_we      = 1'b1;
                            pc_src     = 1'b1;
                            instr_done = 1'b1;
                        end
                        default: instr_done = 1'b1;
                    endcase
                end
                S_MEM: begin
                    bus.mem_req = 1'b1;
                    bus.iord    = 1'b1;
                    bus.mem_we  = (class_q == C_STORE);
                    instr_done  = bus.mem_ready && (class_q == C_STORE);
                end
                S_WB: begin
                    rf_we      = 1'b1;
                    wb_sel     = (class_q == C_LOAD) ? 2'd1 : 2'd0;
                    instr_done = 1'b1;
                end
                S_TRAP: begin
`ifdef MCU_TRAP_EN
                    trap = 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controlunit.sv
// Directed per-cycle vector bench for multicycle_controlunit, plus instruction latency sequences.
module tb_multicycle_controlunit;

    typedef struct packed {
        logic [2:0] st;
        logic       req, we, iord, irwe, pcwe, pcsrc, rfwe;
        logic [1:0] wb;
        logic       asrc;
        logic [3:0] aop;
        logic [1:0] imm;
        logic       done, trap;
    } outs_t;

    typedef struct {
        logic        rst;
        logic [31:0] ins;
        logic [3:0]  fl;
        logic        rdy;
        outs_t       exp;
    } vec_t;

    localparam logic [31:0] SUB  = 32'h40208033;
    localparam logic [31:0] SRAI = 32'h4020D093;
    localparam logic [31:0] ADDI = 32'h40000093;
    localparam logic [31:0] LW   = 32'h00412083;
    localparam logic [31:0] SW   = 32'h00112223;
    localparam logic [31:0] BEQ  = 32'h00208463;
    localparam logic [31:0] BLT  = 32'h0020C463;
    localparam logic [31:0] BGE  = 32'h0020D463;
    localparam logic [31:0] B010 = 32'h0020A463;
    localparam logic [31:0] JAL  = 32'h008000EF;
    localparam logic [31:0] ILL  = 32'h0000007F;

    logic        clock;
    logic        reset;
    logic [31:0] inst;
    logic [3:0]  flags;
    logic        ir_we, pc_we, pc_src, rf_we, alu_src, instr_done, trap;
    logic [1:0]  wb_sel, imm_sel;
    logic [3:0]  alu_op;
    logic [2:0]  state;

    int tests;
    int failed;
    vec_t vq[$];

    multicycle_controlunit_if bus ();

    multicycle_controlunit #(.MEM_TIMEOUT(3)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus.master),
        .inst       (inst),
        .flags      (flags),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .rf_we      (rf_we),
        .wb_sel     (wb_sel),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .imm_sel    (imm_sel),
        .instr_done (instr_done),
        .trap       (trap),
        .state      (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic outs_t o(int st, int req, int we, int iord, int irwe, int pcwe, int pcsrc,
                                int rfwe, int wb, int asrc, int aop, int imm, int done, int tr);
        outs_t r;
        r.st = st[2:0];     r.req = req[0];     r.we = we[0];       r.iord = iord[0];
        r.irwe = irwe[0];   r.pcwe = pcwe[0];   r.pcsrc = pcsrc[0]; r.rfwe = rfwe[0];
        r.wb = wb[1:0];     r.asrc = asrc[0];   r.aop = aop[3:0];   r.imm = imm[1:0];
        r.done = done[0];   r.trap = tr[0];
        return r;
    endfunction

    function automatic outs_t sample();
        return {state, bus.mem_req, bus.mem_we, bus.iord, ir_we, pc_we, pc_src, rf_we,
                wb_sel, alu_src, alu_op, imm_sel, instr_done, trap};
    endfunction

    task automatic add(input logic rst, input logic [31:0] ins, input logic [3:0] fl,
                       input logic rdy, input outs_t e);
        vec_t v;
        v.rst = rst; v.ins = ins; v.fl = fl; v.rdy = rdy; v.exp = e;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reset, then run with zero-wait memory and count cycles from FETCH to instr_done.
    task automatic latency(input string name, input logic [31:0] ins, input int exp);
        int n;
        logic seen;
        @(negedge clock);
        reset = 1'b0; inst = ins; flags = 4'd0; bus.mem_ready = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        n = 0; seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            #1;
            n++;
            if (instr_done === 1'b1) seen = 1'b1;
            else @(negedge clock);
        end
        check(name, seen ? n : -1, exp);
    endtask

    initial begin
        outs_t oRST, oFW, oFR, oDEC, oWBA, oMEMR, oMEMW, oTRAP;
        outs_t act;
        tests = 0; failed = 0;
        reset = 1'b0; inst = SUB; flags = 4'd0; bus.mem_ready = 1'b0;

        oRST  = o(0,0,0,0,0,0,0,0,0,0,0,0,0,0);
        oFW   = o(0,1,0,0,0,0,0,0,0,0,0,0,0,0);
        oFR   = o(0,1,0,0,1,1,0,0,0,0,0,0,0,0);
        oDEC  = o(1,0,0,0,0,0,0,0,0,0,0,0,0,0);
        oWBA  = o(4,0,0,0,0,0,0,1,0,0,0,0,1,0);
        oMEMR = o(3,1,0,1,0,0,0,0,0,0,0,0,0,0);
        oMEMW = o(3,1,1,1,0,0,0,0,0,0,0,0,0,0);
        oTRAP = o(7,0,0,0,0,0,0,0,0,0,0,0,0,1);

        add(0, SUB, 4'h0, 1, oRST);
        add(0, SUB, 4'h0, 1, oRST);
        // R-type sub
        add(1, SUB, 4'h0, 1, oFR);
        add(1, SUB, 4'h0, 1, oDEC);
        add(1, SUB, 4'h0, 1, o(2,0,0,0,0,0,0,0,0,0,8,0,0,0));
        add(1, SUB, 4'h0, 1, oWBA);
        // srai with two fetch wait cycles
        add(1, SRAI, 4'h0, 0, oFW);
        add(1, SRAI, 4'h0, 0, oFW);
        add(1, SRAI, 4'h0, 1, oFR);
        add(1, SRAI, 4'h0, 1, oDEC);
        add(1, SRAI, 4'h0, 1, o(2,0,0,0,0,0,0,0,0,1,13,0,0,0));
        add(1, SRAI, 4'h0, 1, oWBA);
        // addi with inst[30] set: bit 30 must not reach alu_op
        add(1, ADDI, 4'h0, 1, oFR);
        add(1, ADDI, 4'h0, 1, oDEC);
        add(1, ADDI, 4'h0, 1, o(2,0,0,0,0,0,0,0,0,1,0,0,0,0));
        add(1, ADDI, 4'h0, 1, oWBA);
        // load with three memory wait cycles
        add(1, LW, 4'h0, 1, oFR);
        add(1, LW, 4'h0, 0, oDEC);
        add(1, LW, 4'h0, 0, o(2,0,0,0,0,0,0,0,0,1,0,0,0,0));
        add(1, LW, 4'h0, 0, oMEMR);
        add(1, LW, 4'h0, 0, oMEMR);
        add(1, LW, 4'h0, 0, oMEMR);
        add(1, LW, 4'h0, 1, oMEMR);
        add(1, LW, 4'h0, 1, o(4,0,0,0,0,0,0,1,1,0,0,0,1,0));
        // store
        add(1, SW, 4'h0, 1, oFR);
        add(1, SW, 4'h0, 1, oDEC);
        add(1, SW, 4'h0, 1, o(2,0,0,0,0,0,0,0,0,1,0,1,0,0));
        add(1, SW, 4'h0, 1, o(3,1,1,1,0,0,0,0,0,0,0,0,1,0));
        // branches
        add(1, BEQ, 4'h1, 1, oFR);
        add(1, BEQ, 4'h1, 1, oDEC);
        add(1, BEQ, 4'h1, 1, o(2,0,0,0,0,1,1,0,0,0,8,2,1,0));
        add(1, BEQ, 4'h0, 1, oFR);
        add(1, BEQ, 4'h0, 1, oDEC);
        add(1, BEQ, 4'h0, 1, o(2,0,0,0,0,0,0,0,0,0,8,2,1,0));
        add(1, BLT, 4'h8, 1, oFR);
        add(1, BLT, 4'h8, 1, oDEC);
        add(1, BLT, 4'h8, 1, o(2,0,0,0,0,1,1,0,0,0,8,2,1,0));
        add(1, BLT, 4'hA, 1, oFR);
        add(1, BLT, 4'hA, 1, oDEC);
        add(1, BLT, 4'hA, 1, o(2,0,0,0,0,0,0,0,0,0,8,2,1,0));
        add(1, BGE, 4'h0, 1, oFR);
        add(1, BGE, 4'h0, 1, oDEC);
        add(1, BGE, 4'h0, 1, o(2,0,0,0,0,1,1,0,0,0,8,2,1,0));
        add(1, B010, 4'h1, 1, oFR);
        add(1, B010, 4'h1, 1, oDEC);
        add(1, B010, 4'h1, 1, o(2,0,0,0,0,0,0,0,0,0,8,2,1,0));
        // jal
        add(1, JAL, 4'h0, 1, oFR);
        add(1, JAL, 4'h0, 1, oDEC);
        add(1, JAL, 4'h0, 1, o(2,0,0,0,0,1,1,1,2,0,0,3,1,0));
        // store stalled in MEM, reset mid-access, then a stalled fetch
        add(1, SW, 4'h0, 1, oFR);
        add(1, SW, 4'h0, 1, oDEC);
        add(1, SW, 4'h0, 1, o(2,0,0,0,0,0,0,0,0,1,0,1,0,0));
        add(1, SW, 4'h0, 0, oMEMW);
        add(0, SW, 4'h0, 0, oRST);
        add(1, SW, 4'h0, 0, oFW);
        add(1, SW, 4'h0, 0, oFW);
        add(1, SW, 4'h0, 0, oFW);
        add(1, SW, 4'h0, 0, oFW);
`ifdef MCU_TRAP_EN
        add(1, SW, 4'h0, 0, oTRAP);
        add(1, SW, 4'h0, 1, oTRAP);
`else
        add(1, SW, 4'h0, 0, oFW);
        add(1, SW, 4'h0, 0, oFW);
`endif
        // illegal opcode
        add(0, ILL, 4'h0, 1, oRST);
        add(1, ILL, 4'h0, 1, oFR);
        add(1, ILL, 4'h0, 1, oDEC);
`ifdef MCU_TRAP_EN
        add(1, ILL, 4'h0, 1, oTRAP);
        add(1, ILL, 4'h0, 1, oTRAP);
        add(1, ILL, 4'h0, 0, oTRAP);
`else
        add(1, ILL, 4'h0, 1, o(2,0,0,0,0,0,0,0,0,0,0,0,1,0));
        add(1, ILL, 4'h0, 1, oFR);
`endif

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clock);
            reset = vq[i].rst; inst = vq[i].ins; flags = vq[i].fl; bus.mem_ready = vq[i].rdy;
            #1;
            act = sample();
            check($sformatf("vec[%0d]", i), 32'(act), 32'(vq[i].exp));
        end

        latency("lat_r",      SUB,  4);
        latency("lat_i",      SRAI, 4);
        latency("lat_load",   LW,   5);
        latency("lat_store",  SW,   4);
        latency("lat_branch", BEQ,  3);
        latency("lat_jal",    JAL,  3);
`ifndef MCU_TRAP_EN
        latency("lat_illegal", ILL, 3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/multicycle_controlunit.md
# multicycle_controlunit

Multi-cycle FSM control unit for the RV32-subset core. It replaces single-cycle opcode decode with a FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequence that shares one memory port. It waits on a memory ready handshake and evaluates branches from ALU status flags. It sits between the instruction register, the datapath muxes and ALU, and the unified memory interface.

## Interface
- `MEM_TIMEOUT`, default 15: maximum consecutive wait cycles on `mem_ready` before a timeout trap; legal range 1..255.
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: reset, synchronous, active-low.
- `inst`  in  32: current instruction-register contents; stable from DECODE until the next FETCH.
- `flags`  in  4: ALU status {V,C,N,Z}, combinational from the ALU in the same cycle.
- `mem_ready`  in  1: memory has completed the request this cycle.
- `mem_req`  out  1: memory request.
- `mem_we`  out  1: memory write, valid with `mem_req`.
- `iord`  out  1: memory address source; 0 = PC, 1 = ALU result.
- `ir_we`  out  1: load the instruction register.
- `pc_we`  out  1: update the PC.
- `pc_src`  out  1: PC source; 0 = PC+4, 1 = branch/jump target.
- `rf_we`  out  1: register-file write.
- `wb_sel`  out  2: write-back source; 0 = ALU, 1 = memory data, 2 = PC.
- `alu_src`  out  1: ALU operand B; 0 = rs2, 1 = immediate.
- `alu_op`  out  4: ALU operation code.
- `imm_sel`  out  2: immediate format; 0 = I, 1 = S, 2 = B, 3 = J.
- `instr_done`  out  1: one-cycle pulse on the last cycle of each instruction.
- `trap`  out  1: sticky fault indicator.
- `state`  out  3: current state, for debug.

## Operation
- **State encoding:** FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- **Outputs:** combinational from `state`, the registered opcode class, `inst`, `flags` and `mem_ready`. Any output not listed for a state is 0.
- **FETCH:** `mem_req`=1, `iord`=0.
  - On `mem_ready`: `ir_we`=1, `pc_we`=1, `pc_src`=0, then go to DECODE.
- **DECODE:** register the opcode class from `inst[6:0]`, then go to EXEC.
  - Classes: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111.
  - Any other opcode is ILLEGAL; see Configuration.
- **EXEC:**
  - **R:** `alu_src`=0, `alu_op`={inst[30],inst[14:12]}, then go to WB.
  - **I:** `alu_src`=1, `imm_sel`=0, `alu_op`={inst[30]&(inst[14:12]==3'b101), inst[14:12]}, then go to WB.
  - **LOAD:** `alu_src`=1, `imm_sel`=0, `alu_op`=0000, then go to MEM.
  - **STORE:** `alu_src`=1, `imm_sel`=1, `alu_op`=0000, then go to MEM.
  - **BRANCH:** `alu_src`=0, `alu_op`=1000 (sub), `imm_sel`=2, then go to FETCH with `instr_done`.
    - Taken when: funct3 000 and Z; 001 and !Z; 100 and N^V; 101 and !(N^V).
    - If taken: `pc_we`=1, `pc_src`=1.
    - Any other funct3 is not taken.
  - **JAL:** `imm_sel`=3, `rf_we`=1, `wb_sel`=2, `pc_we`=1, `pc_src`=1, then go to FETCH with `instr_done`.
- **MEM:** `mem_req`=1, `iord`=1, `mem_we`=1 for STORE.
  - On `mem_ready`: LOAD goes to WB; STORE goes to FETCH with `instr_done`.
- **WB:** `rf_we`=1, `wb_sel`=1 for LOAD and 0 otherwise, `instr_done`=1, then go to FETCH.
- **TRAP:** `trap`=1. All other outputs are 0. The unit stays in TRAP until reset.
- **Wait counter:** 8 bits, counts consecutive FETCH/MEM cycles with `mem_ready`=0. It clears on `mem_ready` or on any state change.

## Timing
- **Reset:** on a clock edge with `reset`=0: state←FETCH, class←R, counter←0, trap←0.
- **Outputs during reset:** all outputs are forced to 0 combinationally while `reset`=0. `mem_req` is first asserted in the cycle after `reset` goes high.
- **Reset mid-operation:** the instruction in flight is abandoned. No `rf_we` or `mem_we` is asserted in the reset cycle.
- **Latency with zero-wait memory** (FETCH to `instr_done`, inclusive):
  - R/I: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH/JAL: 3 cycles.
- **Memory wait:** each cycle of `mem_ready`=0 adds one cycle. `mem_req` and `iord` hold steady until `mem_ready`.
- **`mem_ready` outside FETCH/MEM:** ignored.
- **`flags`:** sampled only in EXEC of a BRANCH.

## Configuration
- **`MCU_TRAP_EN` defined:**
  - An ILLEGAL opcode in DECODE goes to TRAP.
  - In FETCH/MEM, counter == `MEM_TIMEOUT` with `mem_ready`=0 goes to TRAP on that edge.
- **`MCU_TRAP_EN` undefined:**
  - ILLEGAL is executed as a NOP: EXEC goes to FETCH with `instr_done` and no writes.
  - There is no timeout; the unit waits indefinitely.
  - `trap` is tied to 0, and TRAP is unreachable.

## Test plan
- **Reset:** `reset`=0 for 2 cycles → all outputs 0. `reset`=1 → next cycle `state`=0, `mem_req`=1, `iord`=0.
- **R-type:** `inst`=0x40208033 (sub), zero-wait memory → `alu_op`=1000 in EXEC; `rf_we`=1, `wb_sel`=0 in WB. `instr_done` on cycle 4.
- **LOAD:** `inst`=0x00412083 with 3 wait cycles in MEM → `mem_req`/`iord` high for 4 cycles, `mem_we`=0. WB has `wb_sel`=1. Total 8 cycles.
- **Branch:** BEQ (0x00208463) with `flags`=0001 → `pc_we`=1, `pc_src`=1 in EXEC. Repeat with `flags`=0000 → `pc_we`=0. BLT with `flags`=1000 (V=1, N=0) → taken.
- **Trap, `MCU_TRAP_EN` defined:**
  - `inst`=0x0000007F → `trap`=1 after DECODE and stays high.
  - `mem_ready` held low in FETCH with `MEM_TIMEOUT`=3 → TRAP after 4 cycles.
- **Trap, `MCU_TRAP_EN` undefined:** `inst`=0x0000007F → NOP with `instr_done` in 3 cycles, `trap`=0.
- **Reset mid-MEM:** STORE waiting in MEM, then `reset`=0 → `mem_we` drops in the same cycle. After release, the unit restarts at FETCH.
